// File: rtl/ifetch_queue.sv
// Instruction fetch sequencer: issues aligned 32-bit reads and feeds 16-bit parcels with their PCs to the decoder.
// Optional macro IFQ_BYPASS_EN: an ack into an empty queue presents its first parcel in the same cycle.
module ifetch_queue #(
    parameter int              RV       = 32,
    parameter int              DEPTH    = 4,
    parameter logic [RV-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          fetch_req,
    output logic [RV-1:0] fetch_addr,
    input  logic          fetch_ack,
    input  logic [31:0]   fetch_data,
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    input  logic          stall,
    output logic [15:0]   ins,
    output logic [RV-1:0] ins_pc,
    output logic          idone,
    output logic [1:0]    dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_t;

    state_t          state_q;
    logic [15:0]     mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [RV-1:0]   head_pc_q, fetch_addr_q, saved_addr_q;
    logic            fetch_req_q, skip_lo_q;

    logic [RV-1:0]   target;
    logic            ack_push, q_pop, bp_take, space_ok;
    logic [15:0]     first_par, wr0, wr1;
    logic [1:0]      n_push;

    assign target    = redirect_pc & ~RV'(3);
    assign ack_push  = (state_q == REQ) & fetch_ack & ~redirect;
    assign first_par = skip_lo_q ? fetch_data[31:16] : fetch_data[15:0];

    always_comb begin
        n_push = 2'd0;
        if (ack_push) n_push = skip_lo_q ? 2'd1 : 2'd2;
`ifdef IFQ_BYPASS_EN
        // Empty queue: the first returned parcel goes straight to the decoder.
        bp_take = ack_push & (count_q == '0) & ~stall;
        ins     = (ack_push & (count_q == '0)) ? first_par : mem_q[rd_ptr_q];
        idone   = ((count_q != '0) | (ack_push & (count_q == '0))) & ~stall & ~redirect;
`else
        bp_take = 1'b0;
        ins     = mem_q[rd_ptr_q];
        idone   = (count_q != '0) & ~stall & ~redirect;
`endif
        if (bp_take) n_push = n_push - 2'd1;
        wr0 = bp_take ? fetch_data[31:16] : first_par;
        wr1 = fetch_data[31:16];
    end

    assign q_pop    = idone & (count_q != '0);
    assign count_d  = redirect ? '0 : count_q + CW'(n_push) - CW'(q_pop);
    assign space_ok = count_d <= CW'(DEPTH - 2);

    assign fetch_req  = fetch_req_q;
    assign fetch_addr = fetch_addr_q;
    assign ins_pc     = head_pc_q;
    assign dbg_state  = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= RESET_PC;
            skip_lo_q <= RESET_PC[1];
        end else if (redirect) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            head_pc_q <= redirect_pc & ~RV'(1);
            skip_lo_q <= redirect_pc[1];
        end else begin
            if (n_push != 2'd0) mem_q[wr_ptr_q] <= wr0;
            if (n_push == 2'd2) mem_q[wr_ptr_q + PW'(1)] <= wr1;
            wr_ptr_q <= wr_ptr_q + PW'(n_push);
            if (q_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
            if (idone) head_pc_q <= head_pc_q + RV'(2);
            if (ack_push) skip_lo_q <= 1'b0;
        end
    end

    // A request is only launched with two free slots, so a pending ack can never overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_req_q  <= 1'b0;
            fetch_addr_q <= RESET_PC & ~RV'(3);
            saved_addr_q <= RESET_PC & ~RV'(3);
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        state_q      <= REQ;
                        fetch_req_q  <= 1'b1;
                        fetch_addr_q <= target;
                    end else if (space_ok) begin
                        state_q     <= REQ;
                        fetch_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        if (fetch_ack) begin
                            fetch_addr_q <= target;
                        end else begin
                            state_q      <= DROP;
                            saved_addr_q <= target;
                        end
                    end else if (fetch_ack) begin
                        fetch_addr_q <= fetch_addr_q + RV'(4);
                        if (!space_ok) begin
                            state_q     <= IDLE;
                            fetch_req_q <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    // Stale read still in flight: wait it out, then restart at the redirect target.
                    if (fetch_ack) begin
                        state_q      <= REQ;
                        fetch_addr_q <= redirect ? target : saved_addr_q;
                    end else if (redirect) begin
                        saved_addr_q <= target;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    fetch_req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (RESET_PC=0x100, DEPTH=4); expected ack-to-idone latency follows IFQ_BYPASS_EN.
module tb_ifetch_queue;
`ifdef IFQ_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    localparam logic [1:0] S_IDLE = 2'd0, S_REQ = 2'd1, S_DROP = 2'd2;

    logic        clk = 1'b0;
    logic        reset, fetch_req, fetch_ack, redirect, stall, idone;
    logic [31:0] fetch_addr, fetch_data, redirect_pc, ins_pc;
    logic [15:0] ins;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [47:0] exp_q[$];
    logic [47:0] exp;

    ifetch_queue #(.RV(32), .DEPTH(4), .RESET_PC(32'h100)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_data(fetch_data), .redirect(redirect),
        .redirect_pc(redirect_pc), .stall(stall), .ins(ins), .ins_pc(ins_pc),
        .idone(idone), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'hBBBB_AAAA;
        if (a == 32'h200) return 32'h2222_1111;
        return {a[15:0] + 16'd2, a[15:0]};
    endfunction

    // ack_mode: 0 no ack, 1 ack any pending request from the memory model, 2 forced ack with data
    task automatic clk_cycle(input int ack_mode, input logic [31:0] data, input logic st,
                             input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        stall = st;
        redirect = rd;
        redirect_pc = rpc;
        case (ack_mode)
            1: begin fetch_ack = fetch_req; fetch_data = fetch_req ? mem_word(fetch_addr) : 32'h0; end
            2: begin fetch_ack = 1'b1; fetch_data = data; end
            default: begin fetch_ack = 1'b0; fetch_data = 32'h0; end
        endcase
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; fetch_ack = 1'b0; fetch_data = '0; redirect = 1'b0;
        redirect_pc = '0; stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++; if (fetch_req !== 1'b0) begin n_miss++; $display("FAIL rst_req: got %b want 0", fetch_req); end
        n_vec++; if (fetch_addr !== 32'h100) begin n_miss++; $display("FAIL rst_addr: got %h want 100", fetch_addr); end
        n_vec++; if (idone !== 1'b0) begin n_miss++; $display("FAIL rst_idone: got %b want 0", idone); end
        n_vec++; if (ins !== 16'h0) begin n_miss++; $display("FAIL rst_ins: got %h want 0", ins); end
        n_vec++; if (ins_pc !== 32'h100) begin n_miss++; $display("FAIL rst_pc: got %h want 100", ins_pc); end
        n_vec++; if (dbg_state !== S_IDLE) begin n_miss++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_sequential_fetch;
        logic [31:0] first_addr;
        logic        seen;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_vec++; if (fetch_req !== 1'b0) begin n_miss++; $display("FAIL seq_idle_req: got %b want 0", fetch_req); end
        clk_cycle(1, 0, 0, 0, 0);
        n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h100) begin n_miss++; $display("FAIL seq_first_req: got %b@%h want 1@100", fetch_req, fetch_addr); end
        n_vec++; if (idone !== BYP) begin n_miss++; $display("FAIL seq_ack_latency: idone got %b want %b", idone, BYP); end
        if (idone) begin
            n_vec++; if ({ins_pc, ins} !== {32'h100, 16'hAAAA}) begin n_miss++; $display("FAIL seq_bypass_parcel: got %h@%h want aaaa@100", ins, ins_pc); end
        end else exp_q.push_back({32'h100, 16'hAAAA});
        exp_q.push_back({32'h102, 16'hBBBB});
        exp_q.push_back({32'h104, 16'h0104});
        exp_q.push_back({32'h106, 16'h0106});
        exp_q.push_back({32'h108, 16'h0108});
        seen = 1'b0; first_addr = '0;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            clk_cycle(1, 0, 0, 0, 0);
            if (fetch_ack && !seen) begin seen = 1'b1; first_addr = fetch_addr; end
            if (idone) begin
                exp = exp_q.pop_front();
                n_vec++; if ({ins_pc, ins} !== exp) begin n_miss++; $display("FAIL seq_parcel: got %h@%h want %h@%h", ins, ins_pc, exp[15:0], exp[47:16]); end
            end
        end
        n_vec++; if (first_addr !== 32'h104) begin n_miss++; $display("FAIL seq_second_addr: got %h want 104", first_addr); end
        n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL seq_drain: %0d parcels never presented", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_redirect_idle;
        for (int c = 0; c < 10; c++) clk_cycle(1, 0, 1, 0, 0);
        n_vec++; if (fetch_req !== 1'b0 || dbg_state !== S_IDLE) begin n_miss++; $display("FAIL ri_full_idle: got req=%b st=%0d want req=0 st=0", fetch_req, dbg_state); end
        clk_cycle(1, 0, 0, 1, 32'h202);
        n_vec++; if (idone !== 1'b0) begin n_miss++; $display("FAIL ri_redirect_idone: got %b want 0", idone); end
        clk_cycle(1, 0, 0, 0, 0);
        n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h200) begin n_miss++; $display("FAIL ri_req: got %b@%h want 1@200", fetch_req, fetch_addr); end
        if (idone) begin
            n_vec++; if ({ins_pc, ins} !== {32'h202, 16'h2222}) begin n_miss++; $display("FAIL ri_bypass_parcel: got %h@%h want 2222@202", ins, ins_pc); end
        end else exp_q.push_back({32'h202, 16'h2222});
        exp_q.push_back({32'h204, 16'h0204});
        exp_q.push_back({32'h206, 16'h0206});
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            clk_cycle(1, 0, 0, 0, 0);
            if (idone) begin
                exp = exp_q.pop_front();
                n_vec++; if ({ins_pc, ins} !== exp) begin n_miss++; $display("FAIL ri_parcel: got %h@%h want %h@%h", ins, ins_pc, exp[15:0], exp[47:16]); end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL ri_drain: %0d parcels never presented", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_stall;
        int          acks;
        logic [31:0] pc_e;
        clk_cycle(1, 0, 1, 1, 32'h300);
        acks = 0;
        for (int c = 0; c < 10; c++) begin
            clk_cycle(1, 0, 1, 0, 0);
            if (fetch_ack) acks++;
            if (idone) begin n_vec++; n_miss++; $display("FAIL st_idone_while_stalled: got 1 want 0"); end
        end
        n_vec++; if (acks != 2) begin n_miss++; $display("FAIL st_ack_count: got %0d want 2", acks); end
        n_vec++; if (fetch_req !== 1'b0) begin n_miss++; $display("FAIL st_full_req: got %b want 0", fetch_req); end
        for (int c = 0; c < 4; c++) begin
            clk_cycle(1, 0, 0, 0, 0);
            pc_e = 32'h300 + 32'(2 * c);
            n_vec++; if (idone !== 1'b1 || {ins_pc, ins} !== {pc_e, pc_e[15:0]}) begin n_miss++; $display("FAIL st_release_pop%0d: got %b %h@%h want 1 %h@%h", c, idone, ins, ins_pc, pc_e[15:0], pc_e); end
        end
    endtask

    task automatic test_redirect_drop;
        clk_cycle(1, 0, 0, 1, 32'h108);
        clk_cycle(0, 0, 0, 1, 32'h402);
        n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h108) begin n_miss++; $display("FAIL dr_pending: got %b@%h want 1@108", fetch_req, fetch_addr); end
        for (int c = 0; c < 2; c++) begin
            clk_cycle(0, 0, 0, 0, 0);
            n_vec++; if (dbg_state !== S_DROP || fetch_req !== 1'b1 || fetch_addr !== 32'h108) begin n_miss++; $display("FAIL dr_hold%0d: got st=%0d %b@%h want st=2 1@108", c, dbg_state, fetch_req, fetch_addr); end
        end
        clk_cycle(2, 32'h6666_5555, 0, 0, 0);
        n_vec++; if (idone !== 1'b0) begin n_miss++; $display("FAIL dr_stale_idone: got %b want 0", idone); end
        clk_cycle(1, 0, 0, 0, 0);
        n_vec++; if (dbg_state !== S_REQ || fetch_req !== 1'b1 || fetch_addr !== 32'h400) begin n_miss++; $display("FAIL dr_restart: got st=%0d %b@%h want st=1 1@400", dbg_state, fetch_req, fetch_addr); end
        if (idone) begin
            n_vec++; if ({ins_pc, ins} !== {32'h402, 16'h0402}) begin n_miss++; $display("FAIL dr_bypass_parcel: got %h@%h want 0402@402", ins, ins_pc); end
        end else exp_q.push_back({32'h402, 16'h0402});
        exp_q.push_back({32'h404, 16'h0404});
        exp_q.push_back({32'h406, 16'h0406});
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            clk_cycle(1, 0, 0, 0, 0);
            if (idone) begin
                exp = exp_q.pop_front();
                n_vec++; if ({ins_pc, ins} !== exp) begin n_miss++; $display("FAIL dr_parcel: got %h@%h want %h@%h", ins, ins_pc, exp[15:0], exp[47:16]); end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL dr_drain: %0d parcels never presented", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_redirect_with_ack;
        clk_cycle(1, 0, 0, 1, 32'h500);
        clk_cycle(1, 0, 0, 0, 0);
        clk_cycle(1, 0, 0, 1, 32'h602);
        n_vec++; if (fetch_ack !== 1'b1 || fetch_addr !== 32'h504) begin n_miss++; $display("FAIL ra_ack_setup: got ack=%b @%h want 1@504", fetch_ack, fetch_addr); end
        n_vec++; if (idone !== 1'b0) begin n_miss++; $display("FAIL ra_idone: got %b want 0", idone); end
        clk_cycle(1, 0, 0, 0, 0);
        n_vec++; if (dbg_state !== S_REQ || fetch_req !== 1'b1 || fetch_addr !== 32'h600) begin n_miss++; $display("FAIL ra_restart: got st=%0d %b@%h want st=1 1@600", dbg_state, fetch_req, fetch_addr); end
        if (idone) begin
            n_vec++; if ({ins_pc, ins} !== {32'h602, 16'h0602}) begin n_miss++; $display("FAIL ra_bypass_parcel: got %h@%h want 0602@602", ins, ins_pc); end
        end else exp_q.push_back({32'h602, 16'h0602});
        exp_q.push_back({32'h604, 16'h0604});
        exp_q.push_back({32'h606, 16'h0606});
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            clk_cycle(1, 0, 0, 0, 0);
            if (idone) begin
                exp = exp_q.pop_front();
                n_vec++; if ({ins_pc, ins} !== exp) begin n_miss++; $display("FAIL ra_parcel: got %h@%h want %h@%h", ins, ins_pc, exp[15:0], exp[47:16]); end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL ra_drain: %0d parcels never presented", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid_req;
        clk_cycle(1, 0, 0, 1, 32'h700);
        clk_cycle(0, 0, 0, 0, 0);
        n_vec++; if (fetch_req !== 1'b1 || fetch_addr !== 32'h700) begin n_miss++; $display("FAIL rm_pending: got %b@%h want 1@700", fetch_req, fetch_addr); end
        #2;
        reset = 1'b1;
        #1;
        n_vec++; if (fetch_req !== 1'b0 || fetch_addr !== 32'h100) begin n_miss++; $display("FAIL rm_async_fetch: got %b@%h want 0@100", fetch_req, fetch_addr); end
        n_vec++; if (idone !== 1'b0 || ins !== 16'h0 || ins_pc !== 32'h100) begin n_miss++; $display("FAIL rm_async_out: got %b %h@%h want 0 0000@100", idone, ins, ins_pc); end
        n_vec++; if (dbg_state !== S_IDLE) begin n_miss++; $display("FAIL rm_async_state: got %0d want 0", dbg_state); end
        @(posedge clk); #1;
        reset = 1'b0;
        fetch_ack = 1'b1;
        fetch_data = 32'h9999_8888;
        @(negedge clk);
        n_vec++; if (idone !== 1'b0 || fetch_req !== 1'b0) begin n_miss++; $display("FAIL rm_late_ack: got idone=%b req=%b want 0 0", idone, fetch_req); end
        exp_q.push_back({32'h100, 16'hAAAA});
        exp_q.push_back({32'h102, 16'hBBBB});
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            clk_cycle(1, 0, 0, 0, 0);
            if (idone) begin
                exp = exp_q.pop_front();
                n_vec++; if ({ins_pc, ins} !== exp) begin n_miss++; $display("FAIL rm_parcel: got %h@%h want %h@%h", ins, ins_pc, exp[15:0], exp[47:16]); end
            end
        end
        n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL rm_drain: %0d parcels never presented", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset();
        test_sequential_fetch();
        test_redirect_idle();
        test_stall();
        test_redirect_drop();
        test_redirect_with_ack();
        test_reset_mid_req();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
